// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: ID/EX hazard inputs and front-end control outputs of pipeline_hazard_ctrl
interface pipeline_hazard_ctrl_if #(
   parameter int REG_W = 3,
   parameter int CNT_W = 16
);
   logic [REG_W-1:0] Rs_ID, Rt_ID, RW_Ex;
   logic UseRs_ID, UseRt_ID, MemRd_Ex, RegWrF_Ex, For_ID, Redirect_ID, Ext_Stall;
   logic PC_En, IFID_En, IFID_Flush, IDEX_Bubble;
   logic [CNT_W-1:0] Stall_Cnt, Flush_Cnt;
   modport master (
      output Rs_ID, Rt_ID, RW_Ex, UseRs_ID, UseRt_ID, MemRd_Ex, RegWrF_Ex, For_ID, Redirect_ID, Ext_Stall,
      input  PC_En, IFID_En, IFID_Flush, IDEX_Bubble, Stall_Cnt, Flush_Cnt
   );
   modport slave (
      input  Rs_ID, Rt_ID, RW_Ex, UseRs_ID, UseRt_ID, MemRd_Ex, RegWrF_Ex, For_ID, Redirect_ID, Ext_Stall,
      output PC_En, IFID_En, IFID_Flush, IDEX_Bubble, Stall_Cnt, Flush_Cnt
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use/For stall, redirect flush, freeze; HAZARD_STATS_EN enables Stall_Cnt/Flush_Cnt
module pipeline_hazard_ctrl #(
   parameter int FOR_STALL_CYCLES = 1,
   parameter int REG_W            = 3,
   parameter int CNT_W            = 16,
   parameter bit R0_HARDWIRED     = 1
) (
   input logic CLK,
   input logic RST_n,
   pipeline_hazard_ctrl_if.slave hz
);
   typedef enum logic [1:0] {RUN, FOR_WAIT, FOR_GO} state_t;
   localparam logic [3:0] FOR_CNT = 4'(FOR_STALL_CYCLES - 1);
   state_t state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [REG_W-1:0] rw;
   logic lu, stall, flush;
   assign rw = hz.RW_Ex;
   assign lu = hz.MemRd_Ex & hz.RegWrF_Ex
             & ((hz.UseRs_ID & (hz.Rs_ID == rw)) | (hz.UseRt_ID & (hz.Rt_ID == rw)))
             & ~(R0_HARDWIRED & (rw == '0));
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stall   = 1'b0;
      flush   = 1'b0;
      if (hz.Ext_Stall) begin
         stall = 1'b1;
      end else begin
         case (state_q)
            RUN: begin
               stall = lu | hz.For_ID;
               flush = ~stall & hz.Redirect_ID;
               if (!lu && hz.For_ID) begin
                  state_d = (FOR_STALL_CYCLES == 1) ? FOR_GO : FOR_WAIT;
                  cnt_d   = FOR_CNT;
               end
            end
            FOR_WAIT: begin
               stall   = 1'b1;
               cnt_d   = cnt_q - 4'd1;
               state_d = (cnt_q <= 4'd1) ? FOR_GO : FOR_WAIT;
            end
            FOR_GO: begin
               stall   = lu;
               flush   = ~lu & hz.Redirect_ID;
               state_d = lu ? FOR_GO : RUN;
            end
            default: state_d = RUN;
         endcase
      end
   end
   // reset forces the NOP-injecting output pattern immediately, not at the next edge
   assign hz.PC_En       = RST_n & ~stall;
   assign hz.IFID_En     = RST_n & ~stall;
   assign hz.IFID_Flush  = ~RST_n | flush;
   assign hz.IDEX_Bubble = ~RST_n | stall;
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
`ifdef HAZARD_STATS_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
   always_comb begin
      stall_cnt_d = (!hz.PC_En && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
      flush_cnt_d = (hz.IFID_Flush && flush_cnt_q != '1) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
   end
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end
   assign hz.Stall_Cnt = stall_cnt_q;
   assign hz.Flush_Cnt = flush_cnt_q;
`else
   assign hz.Stall_Cnt = {CNT_W{1'b0}};
   assign hz.Flush_Cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: two configurations (For=3/R0 on, For=1/R0 off/3-bit counters) vs a cycle model
module tb_pipeline_hazard_ctrl;
   logic CLK = 1'b0;
   logic RST_n = 1'b0;
   logic [2:0] rs = '0, rt = '0, rw = '0;
   logic use_rs = 0, use_rt = 0, memrd = 0, regwr = 0, for_id = 0, redir = 0, ext = 0;
   int n_cmp = 0, n_err = 0;

   pipeline_hazard_ctrl_if #(.REG_W(3), .CNT_W(16)) ia ();
   pipeline_hazard_ctrl_if #(.REG_W(3), .CNT_W(3))  ib ();

   pipeline_hazard_ctrl #(.FOR_STALL_CYCLES(3), .REG_W(3), .CNT_W(16), .R0_HARDWIRED(1))
      dut_a (.CLK(CLK), .RST_n(RST_n), .hz(ia));
   pipeline_hazard_ctrl #(.FOR_STALL_CYCLES(1), .REG_W(3), .CNT_W(3), .R0_HARDWIRED(0))
      dut_b (.CLK(CLK), .RST_n(RST_n), .hz(ib));

   assign ia.Rs_ID = rs;  assign ib.Rs_ID = rs;
   assign ia.Rt_ID = rt;  assign ib.Rt_ID = rt;
   assign ia.RW_Ex = rw;  assign ib.RW_Ex = rw;
   assign ia.UseRs_ID = use_rs;  assign ib.UseRs_ID = use_rs;
   assign ia.UseRt_ID = use_rt;  assign ib.UseRt_ID = use_rt;
   assign ia.MemRd_Ex = memrd;   assign ib.MemRd_Ex = memrd;
   assign ia.RegWrF_Ex = regwr;  assign ib.RegWrF_Ex = regwr;
   assign ia.For_ID = for_id;    assign ib.For_ID = for_id;
   assign ia.Redirect_ID = redir; assign ib.Redirect_ID = redir;
   assign ia.Ext_Stall = ext;    assign ib.Ext_Stall = ext;

   always #5 CLK = ~CLK;

   // model: remaining For stall cycles, whether the held For was already served, saturating counts
   int n_for[2] = '{3, 1};
   bit r0[2] = '{1'b1, 1'b0};
   int cmax[2] = '{65535, 7};
   int for_left[2], scnt[2], fcnt[2];
   bit for_go[2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for_left[k] = 0; for_go[k] = 0; scnt[k] = 0; fcnt[k] = 0;
      end
   endtask

   function automatic int stats(input int v);
`ifdef HAZARD_STATS_EN
      return v;
`else
      return 0;
`endif
   endfunction

   task automatic check_out(input int k, input string tag, input logic pc, ifid, fl, bub,
                            input logic [31:0] sc, fc, input bit e_stall, e_fl);
      chk({tag, k ? "/b.pc" : "/a.pc"}, 32'(pc), 32'(!e_stall));
      chk({tag, k ? "/b.ifid" : "/a.ifid"}, 32'(ifid), 32'(!e_stall));
      chk({tag, k ? "/b.flush" : "/a.flush"}, 32'(fl), 32'(e_fl));
      chk({tag, k ? "/b.bubble" : "/a.bubble"}, 32'(bub), 32'(e_stall));
      chk({tag, k ? "/b.scnt" : "/a.scnt"}, sc, 32'(stats(scnt[k])));
      chk({tag, k ? "/b.fcnt" : "/a.fcnt"}, fc, 32'(stats(fcnt[k])));
   endtask

   // called at a negedge with inputs just applied; returns at the following negedge
   task automatic cycle(input string tag);
      bit lu, st, fl;
      #1;
      for (int k = 0; k < 2; k++) begin
         lu = memrd && regwr && ((use_rs && rs == rw) || (use_rt && rt == rw)) && !(r0[k] && rw == 0);
         st = ext || for_left[k] > 0 || lu || (for_id && !for_go[k]);
         fl = !st && redir;
         if (k == 0) check_out(0, tag, ia.PC_En, ia.IFID_En, ia.IFID_Flush, ia.IDEX_Bubble,
                               32'(ia.Stall_Cnt), 32'(ia.Flush_Cnt), st, fl);
         else check_out(1, tag, ib.PC_En, ib.IFID_En, ib.IFID_Flush, ib.IDEX_Bubble,
                        32'(ib.Stall_Cnt), 32'(ib.Flush_Cnt), st, fl);
         if (!ext) begin
            if (for_left[k] > 0) begin
               for_left[k]--;
               if (for_left[k] == 0) for_go[k] = 1;
            end else if (!lu) begin
               if (for_id && !for_go[k]) begin
                  for_left[k] = n_for[k] - 1;
                  for_go[k] = (n_for[k] == 1);
               end else for_go[k] = 0;
            end
         end
         if (st && scnt[k] < cmax[k]) scnt[k]++;
         if (fl && fcnt[k] < cmax[k]) fcnt[k]++;
      end
      @(negedge CLK);
   endtask

   task automatic clear_in();
      rs = 0; rt = 0; rw = 0; use_rs = 0; use_rt = 0; memrd = 0; regwr = 0;
      for_id = 0; redir = 0; ext = 0;
   endtask

   task automatic check_reset(input string tag);
      for (int k = 0; k < 2; k++) begin
         scnt[k] = 0; fcnt[k] = 0;
      end
      check_out(0, tag, ia.PC_En, ia.IFID_En, ia.IFID_Flush, ia.IDEX_Bubble,
                32'(ia.Stall_Cnt), 32'(ia.Flush_Cnt), 1'b1, 1'b1);
      check_out(1, tag, ib.PC_En, ib.IFID_En, ib.IFID_Flush, ib.IDEX_Bubble,
                32'(ib.Stall_Cnt), 32'(ib.Flush_Cnt), 1'b1, 1'b1);
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge CLK);
      check_reset("reset");
      RST_n = 1;
      cycle("idle");
      // load-use on Rs
      memrd = 1; regwr = 1; rw = 3; rs = 3; use_rs = 1;
      cycle("lu_rs");
      clear_in(); cycle("lu_after");
      // load-use on Rt, and a non-matching source
      memrd = 1; regwr = 1; rw = 5; rt = 5; use_rt = 1; rs = 5;
      cycle("lu_rt");
      rt = 4; cycle("lu_nomatch");
      clear_in();
      // R0: hardwired in a, real register in b
      memrd = 1; regwr = 1; rw = 0; rs = 0; use_rs = 1;
      cycle("r0");
      clear_in(); cycle("r0_after");
      // For held until it passes in a (3 stalls then FOR_GO)
      for_id = 1;
      repeat (4) cycle("for_hold");
      clear_in(); cycle("for_done");
      // redirect alone, then together with load-use
      redir = 1; cycle("redir");
      clear_in(); cycle("redir_after");
      redir = 1; memrd = 1; regwr = 1; rw = 2; rs = 2; use_rs = 1;
      cycle("redir_lu");
      memrd = 0; cycle("redir_deferred");
      clear_in();
      // freeze during FOR_WAIT
      for_id = 1; cycle("for_start");
      ext = 1; repeat (4) cycle("ext");
      ext = 0; repeat (3) cycle("for_resume");
      clear_in(); cycle("for_resume_end");
      // load-use during FOR_GO stays there
      for_id = 1; repeat (3) cycle("for_b");
      memrd = 1; regwr = 1; rw = 1; rt = 1; use_rt = 1; cycle("forgo_lu");
      memrd = 0; cycle("forgo_pass");
      clear_in(); cycle("forgo_end");
      // asynchronous reset mid-FOR_WAIT
      for_id = 1; repeat (2) cycle("for_rst");
      #2 RST_n = 0;
      #1 check_reset("async_rst");
      model_reset();
      @(negedge CLK);
      check_reset("rst_held");
      RST_n = 1; clear_in();
      cycle("post_rst");
      // randomized traffic
      for (int i = 0; i < 500; i++) begin
         rs = 3'($urandom); rt = 3'($urandom); rw = 3'($urandom_range(0, 3));
         use_rs = 1'($urandom); use_rt = 1'($urandom);
         memrd = 1'($urandom); regwr = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 3) == 0) for_id = ~for_id;
         redir = ($urandom_range(0, 3) == 0);
         ext = ($urandom_range(0, 7) == 0);
         cycle("rand");
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
